// File: rtl/eth_frame_builder_axis_gen2.sv
// eth_frame_builder_axis_gen2: prepends the L2 header (802.1Q tag optional via ETH_FB_VLAN_EN) to an AXI-Stream payload and pads runts
module eth_frame_builder_axis_gen2 #(
  parameter int DATA_W  = 64,
  parameter int MIN_LEN = 60
) (
  input  logic                cclk,
  input  logic                reset,
  input  logic [47:0]         dMAC,
  input  logic [47:0]         sMAC,
  input  logic [15:0]         eType,
`ifdef ETH_FB_VLAN_EN
  input  logic                vlan_en,
  input  logic [15:0]         vlan_tci,
`endif
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                busy
);
  localparam int KW = DATA_W / 8;
  localparam int HW = (18 + KW) * 8;
  localparam logic [16:0] MINL = 17'(MIN_LEN);
  typedef enum logic [2:0] {IDLE, HDR, BODY, TAIL, PAD} state_t;
  state_t state, nxt_state;
  logic [HW-1:0] hbuf, nxt_hbuf, hv;
  logic [KW-1:0] res_k, nxt_res_k, nxt_tk, bk, nres_k, fk_in, fk;
  logic [4:0] hrem, nxt_hrem, h_now, h_frm, hb_now, off_now, off;
  logic [15:0] cnt, nxt_cnt, tsat, fsat;
  logic [DATA_W-1:0] nxt_td, in_m, rd, bd, nres;
  logic [16:0] n, t, left, room, fn, fc;
  logic [7:0] ob8, kob8;
  logic tu_q, nxt_tu, nxt_tv, nxt_tl, nxt_tus, adv, acc, start, fin, need, flast;
  function automatic logic [16:0] pcnt(input logic [KW-1:0] k);
    pcnt = '0;
    for (int i = 0; i < KW; i++) pcnt = pcnt + 17'(k[i]);
  endfunction
  function automatic logic [KW-1:0] top_ones(input logic [16:0] c);
    return ~({KW{1'b1}} >> c);
  endfunction
  function automatic logic [DATA_W-1:0] kmask(input logic [KW-1:0] k);
    kmask = '0;
    for (int i = 0; i < KW; i++) kmask[i*8 +: 8] = {8{k[i]}};
  endfunction
  assign start = state == IDLE && s_axis_tvalid && !m_axis_tvalid;
`ifdef ETH_FB_VLAN_EN
  logic vl_q;
  // tag choice is frozen for the whole frame at frame start
  always_ff @(posedge cclk or posedge reset)
    if (reset) vl_q <= 1'b0;
    else if (start) vl_q <= vlan_en;
  assign h_now = vlan_en ? 5'd18 : 5'd14;
  assign h_frm = vl_q ? 5'd18 : 5'd14;
  assign hv = vlan_en ? {dMAC, sMAC, 16'h8100, vlan_tci, eType, {(KW*8){1'b0}}}
                      : {dMAC, sMAC, eType, 32'h0, {(KW*8){1'b0}}};
`else
  assign h_now = 5'd14;
  assign h_frm = 5'd14;
  assign hv = {dMAC, sMAC, eType, 32'h0, {(KW*8){1'b0}}};
`endif
  assign hb_now = h_now / 5'(KW);
  assign off_now = h_now % 5'(KW);
  assign off = h_frm % 5'(KW);
  assign ob8 = {off, 3'b000};
  assign kob8 = 8'(KW * 8) - ob8;
  assign adv = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = state == BODY && adv;
  assign acc = s_axis_tvalid && s_axis_tready;
  assign busy = state != IDLE || m_axis_tvalid;
  assign in_m = s_axis_tdata & kmask(s_axis_tkeep);
  assign rd = hbuf[HW-1 -: DATA_W];
  assign bd = rd | (in_m >> ob8);
  assign bk = res_k | (s_axis_tkeep >> off);
  assign nres = in_m << kob8;
  assign nres_k = s_axis_tkeep << (5'(KW) - off);
  assign fin = s_axis_tlast && nres_k == '0;
  assign fk_in = state == BODY ? bk : state == TAIL ? res_k : '0;
  assign n = pcnt(fk_in);
  assign t = {1'b0, cnt} + n;
  assign tsat = t[16] ? 16'hFFFF : t[15:0];
  assign need = t < MINL;
  assign left = MINL - t;
  assign room = 17'(KW) - n;
  assign fn = need ? (left > room ? 17'(KW) : n + left) : n;
  assign flast = !(need && left > room);
  assign fc = {1'b0, cnt} + fn;
  assign fsat = fc[16] ? 16'hFFFF : fc[15:0];
  assign fk = top_ones(fn);
  // next-state and next output beat; a final data beat is zero-filled in place toward MIN_LEN
  always_comb begin
    nxt_state = state;
    nxt_hbuf = hbuf;
    nxt_res_k = res_k;
    nxt_hrem = hrem;
    nxt_cnt = cnt;
    nxt_tu = tu_q;
    nxt_td = m_axis_tdata;
    nxt_tk = m_axis_tkeep;
    nxt_tl = m_axis_tlast;
    nxt_tus = m_axis_tuser;
    nxt_tv = m_axis_tvalid && !m_axis_tready;
    case (state)
      IDLE: if (start) begin
        nxt_hbuf = hv;
        nxt_res_k = top_ones(17'(off_now));
        nxt_cnt = '0;
        nxt_tu = 1'b0;
        nxt_state = BODY;
        if (hb_now != 5'd0) begin
          nxt_td = hv[HW-1 -: DATA_W];
          nxt_tk = '1;
          nxt_tl = 1'b0;
          nxt_tus = 1'b0;
          nxt_tv = 1'b1;
          nxt_hbuf = hv << (KW * 8);
          nxt_cnt = 16'(KW);
          nxt_hrem = hb_now - 5'd1;
          nxt_state = hb_now == 5'd1 ? BODY : HDR;
        end
      end
      HDR: if (adv) begin
        nxt_td = rd;
        nxt_tk = '1;
        nxt_tl = 1'b0;
        nxt_tus = 1'b0;
        nxt_tv = 1'b1;
        nxt_hbuf = hbuf << (KW * 8);
        nxt_cnt = cnt + 16'(KW);
        nxt_hrem = hrem - 5'd1;
        nxt_state = hrem == 5'd1 ? BODY : HDR;
      end
      BODY: if (acc) begin
        nxt_td = bd;
        nxt_tv = 1'b1;
        nxt_hbuf = {nres, {(HW-DATA_W){1'b0}}};
        nxt_res_k = nres_k;
        nxt_tk = fin ? fk : bk;
        nxt_tl = fin && flast;
        nxt_tus = fin && flast && s_axis_tuser;
        nxt_cnt = fin ? fsat : tsat;
        nxt_tu = s_axis_tlast ? s_axis_tuser : tu_q;
        nxt_state = !s_axis_tlast ? BODY : !fin ? TAIL : flast ? IDLE : PAD;
      end
      TAIL, PAD: if (adv) begin
        nxt_td = state == TAIL ? rd : '0;
        nxt_tk = fk;
        nxt_tv = 1'b1;
        nxt_tl = flast;
        nxt_tus = flast && tu_q;
        nxt_cnt = fsat;
        nxt_res_k = '0;
        nxt_state = flast ? IDLE : PAD;
      end
      default: nxt_state = IDLE;
    endcase
  end
  // state and the single output register stage
  always_ff @(posedge cclk or posedge reset)
    if (reset) begin
      state <= IDLE;
      hbuf <= '0;
      res_k <= '0;
      hrem <= '0;
      cnt <= '0;
      tu_q <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
    end else begin
      state <= nxt_state;
      hbuf <= nxt_hbuf;
      res_k <= nxt_res_k;
      hrem <= nxt_hrem;
      cnt <= nxt_cnt;
      tu_q <= nxt_tu;
      m_axis_tdata <= nxt_td;
      m_axis_tkeep <= nxt_tk;
      m_axis_tvalid <= nxt_tv;
      m_axis_tlast <= nxt_tl;
      m_axis_tuser <= nxt_tus;
    end
endmodule

// File: tb/tb_eth_frame_builder_axis_gen2.sv
// tb_eth_frame_builder_axis_gen2: directed bench for the 64-bit frame builder
module tb_eth_frame_builder_axis_gen2;
  logic cclk = 1'b0, reset = 1'b1;
  logic [47:0] dMAC = 48'h112233445566, sMAC = 48'h5076afa8f5e8;
  logic [15:0] eType = 16'h0800;
`ifdef ETH_FB_VLAN_EN
  logic vlan_en = 1'b0;
  logic [15:0] vlan_tci = 16'h0;
`endif
  logic [63:0] s_tdata = '0, m_tdata;
  logic [7:0] s_tkeep = '0, m_tkeep;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic m_tvalid, m_tready = 1'b1, m_tlast, m_tuser, busy;
  int total = 0, bad = 0;
  logic [63:0] got_d[$], exp_d[$];
  logic [7:0] got_k[$], exp_k[$];
  logic got_l[$], got_u[$];

  always #5 cclk = ~cclk;

  eth_frame_builder_axis_gen2 #(.DATA_W(64), .MIN_LEN(60)) dut (
    .cclk(cclk), .reset(reset), .dMAC(dMAC), .sMAC(sMAC), .eType(eType),
`ifdef ETH_FB_VLAN_EN
    .vlan_en(vlan_en), .vlan_tci(vlan_tci),
`endif
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pl(input int s);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = 8'(s + i);
    return r;
  endfunction

  function automatic logic [63:0] beat_d(input int b, input int nb);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = (8*b + i < nb) ? 8'(8*b + i) : 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] beat_k(input int b, input int nb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = 8*b + i < nb;
    return r;
  endfunction

  task automatic run_frame(input int nb, input bit tu, input bit stall, input bit rst_mid);
    int nbeats = (nb + 7) / 8;
    int ib = 0, cyc = 0, sc = 0;
    bit done = 0, aborted = 0;
    logic [63:0] held = '0;
    got_d.delete(); got_k.delete(); got_l.delete(); got_u.delete();
    while (!done && cyc < 200) begin
      @(negedge cclk);
      s_tvalid = ib < nbeats;
      s_tdata = beat_d(ib, nb);
      s_tkeep = beat_k(ib, nb);
      s_tlast = ib == nbeats - 1;
      s_tuser = tu && s_tlast;
      m_tready = 1'b1;
      if (stall && cyc == 2) begin
        dMAC = 48'hFFFFFFFFFFFF;
        eType = 16'h86DD;
      end
      if (stall && got_d.size() == 3 && m_tvalid && sc < 3) begin
        m_tready = 1'b0;
        if (sc == 0) held = m_tdata;
        else chk("bp_hold", m_tdata, held);
        sc++;
      end
      #1;
      if (cyc == 1) begin
        chk("lat_tvalid", 64'(m_tvalid), 64'd1);
        chk("busy_run", 64'(busy), 64'd1);
      end
      if (!m_tready) chk("bp_srdy", 64'(s_tready), 64'd0);
      if (rst_mid && got_d.size() == 4 && m_tvalid) begin
        reset = 1'b1;
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        s_tvalid = 1'b0;
        @(negedge cclk);
        reset = 1'b0;
        repeat (3) @(negedge cclk);
        #1;
        chk("rst_idle", 64'(m_tvalid), 64'd0);
        aborted = 1;
        break;
      end
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata);
        got_k.push_back(m_tkeep);
        got_l.push_back(m_tlast);
        got_u.push_back(m_tuser);
        done = m_tlast;
      end
      if (s_tvalid && s_tready) ib++;
      cyc++;
      @(posedge cclk);
    end
    dMAC = 48'h112233445566;
    eType = 16'h0800;
    if (!aborted) begin
      if (!done) chk("timeout", 64'd1, 64'd0);
      @(negedge cclk);
      #1;
      chk("busy_end", 64'(busy), 64'd0);
    end
  endtask

  task automatic check_frame(input string name, input bit tu);
    int ne = exp_d.size();
    chk({name, "_beats"}, 64'(got_d.size()), 64'(ne));
    for (int i = 0; i < got_d.size() && i < ne; i++) begin
      chk($sformatf("%s_d%0d", name, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_k%0d", name, i), 64'(got_k[i]), 64'(exp_k[i]));
      chk($sformatf("%s_l%0d", name, i), 64'(got_l[i]), 64'(i == ne - 1));
      chk($sformatf("%s_u%0d", name, i), 64'(got_u[i]), 64'(tu && i == ne - 1));
    end
  endtask

  task automatic set_keep(input int nfull, input logic [7:0] lk);
    exp_k.delete();
    for (int i = 0; i < nfull; i++) exp_k.push_back(8'hFF);
    exp_k.push_back(lk);
  endtask

  task automatic exp_runt(input logic [63:0] last_d);
    exp_d.delete();
    exp_d.push_back(64'h1122334455665076);
    exp_d.push_back(64'hafa8f5e808000001);
    for (int s = 2; s <= 34; s += 8) exp_d.push_back(pl(s));
    exp_d.push_back(last_d);
    set_keep(7, 8'hF0);
  endtask

  initial begin
    repeat (2) @(negedge cclk);
    #1;
    chk("reset_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset_tdata", m_tdata, 64'd0);
    chk("reset_tkeep", 64'(m_tkeep), 64'd0);
    chk("reset_tlast", 64'(m_tlast), 64'd0);
    chk("reset_tuser", 64'(m_tuser), 64'd0);
    chk("reset_srdy", 64'(s_tready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    run_frame(42, 0, 0, 0);
    exp_runt(64'h0);
    check_frame("runt", 0);
    run_frame(43, 0, 0, 0);
    exp_runt(64'h2A00000000000000);
    check_frame("odd", 0);
    run_frame(64, 0, 0, 0);
    exp_d.delete();
    exp_d.push_back(64'h1122334455665076);
    exp_d.push_back(64'hafa8f5e808000001);
    for (int s = 2; s <= 50; s += 8) exp_d.push_back(pl(s));
    exp_d.push_back(64'h3a3b3c3d3e3f0000);
    set_keep(9, 8'hFC);
    check_frame("nopad", 0);
    run_frame(42, 0, 1, 0);
    exp_runt(64'h0);
    check_frame("bp", 0);
    run_frame(42, 1, 0, 0);
    check_frame("tuser", 1);
    run_frame(42, 0, 0, 1);
    run_frame(42, 0, 0, 0);
    check_frame("post_rst", 0);
`ifdef ETH_FB_VLAN_EN
    vlan_en = 1'b1;
    vlan_tci = 16'h0064;
    run_frame(42, 0, 0, 0);
    exp_d.delete();
    exp_d.push_back(64'h1122334455665076);
    exp_d.push_back(64'hafa8f5e881000064);
    exp_d.push_back(64'h0800000102030405);
    for (int s = 6; s <= 30; s += 8) exp_d.push_back(pl(s));
    exp_d.push_back(64'h2627282900000000);
    set_keep(7, 8'hF0);
    check_frame("vlan", 0);
    vlan_en = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_frame_builder_axis_gen2.md
# eth_frame_builder_axis_gen2

Parametrised second-generation AXI-Stream Ethernet frame builder. It prepends a 14-byte L2 header (dMAC, sMAC, eType), or an 18-byte header with an optional 802.1Q tag, to a payload stream. It pads runts to a minimum length and honours full downstream backpressure, so it has no pipe-jam error. It sits between the IP/UDP packetiser and the MAC/FCS stage.

## Interface
- DATA_W, 64, stream width in bits; legal values 32, 64, 128. KEEP_W = DATA_W/8.
- MIN_LEN, 60, minimum output frame length in bytes, FCS excluded. 0 disables padding.

- cclk  in  1  clock
- reset  in  1  reset; one clock, asynchronous, active-high
- dMAC  in  48  destination MAC; sampled at frame start
- sMAC  in  48  source MAC; sampled at frame start
- eType  in  16  EtherType; sampled at frame start
- vlan_en  in  1  insert 802.1Q tag; sampled at frame start (present only with ETH_FB_VLAN_EN)
- vlan_tci  in  16  tag control info (present only with ETH_FB_VLAN_EN)
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_W/KEEP_W/1/1/1/1  payload slave
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  DATA_W/KEEP_W/1/1/1/1  frame master
- busy  out  1  high from frame start until the last output beat is accepted

## Operation
- Byte order: byte 0 is tdata[DATA_W-1:DATA_W-8], qualified by tkeep[KEEP_W-1].
- Inbound tkeep is contiguous from the MSB. Only the tlast beat may be partial.
- Header order: dMAC, sMAC, [0x8100, vlan_tci], eType. All fields are big-endian.
- H = 14 or 18 bytes. The payload is shifted by H mod KEEP_W bytes. Residual bytes are carried into the next beat.
- States:
  - IDLE: s_axis_tready=0. When s_axis_tvalid=1, latch the header fields and go to HDR.
  - HDR: emit floor(H/KEEP_W) beats that are all header. Go to BODY.
  - BODY: each output beat merges the header/residual bytes with the accepted input bytes.
    - On an accepted tlast, go to TAIL if residual bytes remain.
    - Otherwise go to PAD if the length is below MIN_LEN.
    - Otherwise the beat is the last beat; go to IDLE.
  - TAIL: emit the residual bytes. Go to PAD or IDLE by the same length rule.
  - PAD: emit zero bytes until the byte count reaches MIN_LEN. tkeep is exact on the final beat.
- Byte counter: 16 bits, saturating at 0xFFFF. Padding decisions use the saturated value.
- m_axis_tuser = 1 only on the output tlast beat, and only if s_axis_tuser was 1 on the accepted input tlast beat.
- Header inputs may change mid-frame with no effect on the frame in progress.

## Timing
- The output is a single register stage.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
  - s_axis_tready = (state==BODY) && (!m_axis_tvalid || m_axis_tready). This is a combinational path from m_axis_tready.
- While m_axis_tvalid=1 && m_axis_tready=0, all m_axis_* outputs hold stable.
- Latency: the first header beat is valid on the cycle after s_axis_tvalid is sampled high in IDLE.
- At least one cycle with m_axis_tvalid=0 separates frames.
- Reset values: every m_axis_* output is 0, s_axis_tready=0, busy=0, state=IDLE.
- Reset asserted mid-frame:
  - Outputs go to reset values immediately and the partial frame is discarded, with no tlast.
  - After release, the next frame starts only on a fresh s_axis_tvalid in IDLE.
- s_axis_tvalid dropping mid-frame in BODY stalls the output (m_axis_tvalid=0 once the register drains). It is not an error.

## Configuration
- ETH_FB_VLAN_EN defined:
  - vlan_en and vlan_tci exist.
  - vlan_en=1 selects H=18 with the tag 0x8100 followed by vlan_tci.
  - vlan_en=0 selects H=14.
- Undefined: the ports are absent and H=14 is a constant, so the shift logic reduces to a single offset.

## Test plan
- Runt pad (DATA_W=64, no VLAN): 42-byte payload 0x00..0x29 (5 full beats, then 2 bytes with tkeep=0xC0), dMAC=11:22:33:44:55:66, sMAC=50:76:af:a8:f5:e8, eType=0x0800.
  - Beat 0 = 0x1122334455665076; beat 1 = 0xafa8f5e808000001.
  - Beats 2-6 = 0x02..0x29.
  - Beat 7 = 0, tkeep=0xF0, tlast=1. 8 beats and 60 bytes in total.
- Odd tail: 43-byte payload ending with tkeep=0xE0 -> beat 7 = 0x2A000000_00000000, tkeep=0xF0, tlast=1.
- No pad: 64-byte payload of 8 full beats -> 10 beats out; the last beat has tkeep=0xFC and carries payload bytes 58..63.
- Backpressure: hold m_axis_tready=0 for 3 cycles on beat 3 -> beat 3 is stable for all 3 cycles, s_axis_tready=0, and the output sequence is identical to the first scenario.
- Error flag: s_axis_tuser=1 with tlast on the first scenario's stimulus -> m_axis_tuser=1 on beat 7 only.
- VLAN (ETH_FB_VLAN_EN, vlan_en=1, vlan_tci=0x0064), 42-byte payload:
  - Beat 1 = 0xafa8f5e881000064.
  - Beat 2 = 0x0800000102030405.
  - Beat 7 = 0x26272829_00000000, tkeep=0xF0, with no padding.
- Reset pulse during beat 4 -> all outputs are 0 on the next edge; a following frame is correct.
